// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
// fifo_wr_ctrl : write-domain pointer/flag controller for a dual-clock FIFO
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_en,
    output logic [ADDR_WIDTH:0]   gray_w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          af_next;

    assign w_en      = w_inc & ~w_full;
    assign w_addr    = wbin[ADDR_WIDTH-1:0];
    assign wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, w_en};
    assign gray_next = wbin_next ^ (wbin_next >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign level_next = wbin_next - rbin;
    assign full_next  = (gray_next == (wq2_rptr ^ FULL_MASK));
    assign af_next    = (level_next >= af_thresh);

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            wbin          <= '0;
            gray_w_ptr    <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
            w_overflow    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            gray_w_ptr    <= gray_next;
            w_full        <= full_next;
            w_almost_full <= af_next;
            w_level       <= level_next;
            // A rejected write on the same edge as a clear keeps the flag set.
            if (w_inc && w_full) begin
                w_overflow <= 1'b1;
            end else if (ovf_clr) begin
                w_overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
